// File: rtl/va_req_gen.sv
// va_req_gen: per-input-VC request generator and VC state controller.
// Walks one packet through IDLE -> RC -> VA -> ACTIVE, raises a one-hot
// output-VC request towards the VC allocator while in VA, and holds the
// granted output port/VC until the tail flit leaves.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   head_valid    head flit present at the front of this input VC
//   route_valid   route computation result valid
//   route_port    output port from route computation
//   out_vc_avail  availability of every output VC, bit p*V+v
//   vc_granted    VC allocator grant for this input VC
//   tail_sent     tail flit won switch traversal this cycle
//   req_vc        one-hot (or zero) output-VC request, bit p*V+v
//   state         IDLE=0, RC=1, VA=2, ACTIVE=3
//   alloc_port    allocated output port
//   alloc_vc      allocated output VC
//   vc_active     state == ACTIVE
//   route_err     sticky flag for route_port >= N
module va_req_gen #(
    parameter int unsigned N  = 5,
    parameter int unsigned V  = 4,
    parameter int unsigned PW = $clog2(N),
    parameter int unsigned VW = $clog2(V)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            head_valid,
    input  logic            route_valid,
    input  logic [PW-1:0]   route_port,
    input  logic [N*V-1:0]  out_vc_avail,
    input  logic            vc_granted,
    input  logic            tail_sent,
    output logic [N*V-1:0]  req_vc,
    output logic [1:0]      state,
    output logic [PW-1:0]   alloc_port,
    output logic [VW-1:0]   alloc_vc,
    output logic            vc_active,
    output logic            route_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RC     = 2'd1,
        VA     = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   port_d;
    logic [VW-1:0]   vc_d;
    logic [VW-1:0]   rr_ptr;
    logic [VW-1:0]   rr_d;
    logic            err_d;

    logic [V-1:0]    cand;
    logic [V-1:0]    onehot;
    logic            found;
    logic [VW-1:0]   sel;
    logic            port_ok;
    int unsigned     idx;

    // Compare at 32 bits so a port width that exactly fits N cannot alias.
    assign port_ok = (32'(alloc_port) < N);

    // Availability slice of the latched output port.
    always_comb begin
        cand = '0;
        for (int unsigned p = 0; p < N; p++) begin
            if (32'(alloc_port) == p) begin
                cand = out_vc_avail[p*V +: V];
            end
        end
    end

    // Round-robin pick: first available VC at or after rr_ptr, wrapping at V.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < V; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= V) begin
                idx = idx - V;
            end
            if (!found && cand[VW'(idx)]) begin
                found = 1'b1;
                sel   = VW'(idx);
            end
        end
    end

    // Request is placed only in the latched port's slice, so it is never multi-hot.
    always_comb begin
        onehot = '0;
        req_vc = '0;
        for (int unsigned v = 0; v < V; v++) begin
            onehot[v] = (32'(sel) == v);
        end
        if (state_q == VA && found && port_ok) begin
            for (int unsigned p = 0; p < N; p++) begin
                if (32'(alloc_port) == p) begin
                    req_vc[p*V +: V] = onehot;
                end
            end
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        port_d  = alloc_port;
        vc_d    = alloc_vc;
        rr_d    = rr_ptr;
        err_d   = route_err;
        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    state_d = RC;
                end
            end
            RC: begin
                if (route_valid) begin
                    port_d  = route_port;
                    state_d = VA;
                    if (32'(route_port) >= N) begin
                        err_d = 1'b1;
                    end
                end
            end
            VA: begin
                // A bad port has no escape: only reset leaves this state.
                if (!port_ok) begin
                    err_d = 1'b1;
                end else if (vc_granted && found) begin
                    vc_d    = sel;
                    rr_d    = (32'(sel) == V - 1) ? '0 : sel + VW'(1);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (tail_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and allocation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            alloc_port <= '0;
            alloc_vc   <= '0;
            rr_ptr     <= '0;
            route_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alloc_port <= port_d;
            alloc_vc   <= vc_d;
            rr_ptr     <= rr_d;
            route_err  <= err_d;
        end
    end

    assign state     = state_q;
    assign vc_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_va_req_gen.sv
// tb_va_req_gen: directed vector table plus hand-written corner sequences
// for va_req_gen with N=5, V=4.
module tb_va_req_gen;

    logic        clk;
    logic        rst;
    logic        head_valid;
    logic        route_valid;
    logic [2:0]  route_port;
    logic [19:0] out_vc_avail;
    logic        vc_granted;
    logic        tail_sent;
    logic [19:0] req_vc;
    logic [1:0]  state;
    logic [2:0]  alloc_port;
    logic [1:0]  alloc_vc;
    logic        vc_active;
    logic        route_err;

    int checks = 0;
    int errors = 0;

    va_req_gen #(.N(5), .V(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .head_valid   (head_valid),
        .route_valid  (route_valid),
        .route_port   (route_port),
        .out_vc_avail (out_vc_avail),
        .vc_granted   (vc_granted),
        .tail_sent    (tail_sent),
        .req_vc       (req_vc),
        .state        (state),
        .alloc_port   (alloc_port),
        .alloc_vc     (alloc_vc),
        .vc_active    (vc_active),
        .route_err    (route_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hv;
        logic        rv;
        logic [2:0]  rp;
        logic [19:0] av;
        logic        gnt;
        logic        tail;
        logic [1:0]  e_st;
        logic [19:0] e_req;
        logic [2:0]  e_ap;
        logic [1:0]  e_vc;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic hv, logic rv, logic [2:0] rp, logic [19:0] av,
                                logic gnt, logic tail, logic [1:0] st, logic [19:0] rq,
                                logic [2:0] ap, logic [1:0] vc, logic err);
        vec_t t;
        t.hv = hv; t.rv = rv; t.rp = rp; t.av = av; t.gnt = gnt; t.tail = tail;
        t.e_st = st; t.e_req = rq; t.e_ap = ap; t.e_vc = vc; t.e_err = err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, then let them settle.
    task automatic drive(input logic hv, input logic rv, input logic [2:0] rp,
                         input logic [19:0] av, input logic gnt, input logic tail);
        @(negedge clk);
        rst          = 1'b0;
        head_valid   = hv;
        route_valid  = rv;
        route_port   = rp;
        out_vc_avail = av;
        vc_granted   = gnt;
        tail_sent    = tail;
        #1;
    endtask

    // Reset for one edge; availability is left as-is so a dropped request is visible.
    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        head_valid  = 1'b0;
        route_valid = 1'b0;
        vc_granted  = 1'b0;
        tail_sent   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    localparam logic [19:0] F = 20'hFFFFF;

    initial begin
        rst = 1'b0; head_valid = 1'b0; route_valid = 1'b0; route_port = '0;
        out_vc_avail = '0; vc_granted = 1'b0; tail_sent = 1'b0;

        // Basic flow to port 2, spurious grant/tail in IDLE, round robin to rr=3,
        // wrap-around pick, and the one-cycle bubble after tail+head.
        tbl.push_back(mk(1,0,0,0,      0,0, 0,20'h0,    0,0,0));
        tbl.push_back(mk(0,1,2,0,      0,0, 1,20'h0,    0,0,0));
        tbl.push_back(mk(0,0,0,F,      0,0, 2,20'h00100,2,0,0));
        tbl.push_back(mk(0,0,0,F,      1,0, 2,20'h00100,2,0,0));
        tbl.push_back(mk(0,0,0,F,      0,0, 3,20'h0,    2,0,0));
        tbl.push_back(mk(0,0,0,F,      0,1, 3,20'h0,    2,0,0));
        tbl.push_back(mk(0,0,0,F,      1,1, 0,20'h0,    2,0,0));
        tbl.push_back(mk(0,0,0,0,      0,0, 0,20'h0,    2,0,0));
        tbl.push_back(mk(1,0,0,0,      0,0, 0,20'h0,    2,0,0));
        tbl.push_back(mk(0,1,1,0,      0,0, 1,20'h0,    2,0,0));
        tbl.push_back(mk(0,0,0,F,      1,0, 2,20'h00020,1,0,0));
        tbl.push_back(mk(0,0,0,0,      0,1, 3,20'h0,    1,1,0));
        tbl.push_back(mk(1,0,0,0,      0,0, 0,20'h0,    1,1,0));
        tbl.push_back(mk(0,1,1,0,      0,0, 1,20'h0,    1,1,0));
        tbl.push_back(mk(0,0,0,F,      1,0, 2,20'h00040,1,1,0));
        tbl.push_back(mk(0,0,0,0,      0,1, 3,20'h0,    1,2,0));
        tbl.push_back(mk(1,0,0,0,      0,0, 0,20'h0,    1,2,0));
        tbl.push_back(mk(0,1,1,0,      0,0, 1,20'h0,    1,2,0));
        tbl.push_back(mk(0,0,0,20'h50, 0,0, 2,20'h00010,1,2,0));
        tbl.push_back(mk(0,0,0,20'h50, 1,0, 2,20'h00010,1,2,0));
        tbl.push_back(mk(0,0,0,0,      0,0, 3,20'h0,    1,0,0));
        tbl.push_back(mk(1,0,0,0,      0,1, 3,20'h0,    1,0,0));
        tbl.push_back(mk(1,0,0,0,      0,0, 0,20'h0,    1,0,0));
        tbl.push_back(mk(0,0,0,0,      0,0, 1,20'h0,    1,0,0));

        do_reset();
        chk("reset_state", 32'(state), 0);
        chk("reset_req", 32'(req_vc), 0);
        chk("reset_port", 32'(alloc_port), 0);
        chk("reset_vc", 32'(alloc_vc), 0);
        chk("reset_err", 32'(route_err), 0);
        chk("reset_active", 32'(vc_active), 0);
        chk("reset_rr", 32'(dut.rr_ptr), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].hv, tbl[i].rv, tbl[i].rp, tbl[i].av, tbl[i].gnt, tbl[i].tail);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].e_st));
            chk($sformatf("v%0d_req", i), 32'(req_vc), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_port", i), 32'(alloc_port), 32'(tbl[i].e_ap));
            chk($sformatf("v%0d_vc", i), 32'(alloc_vc), 32'(tbl[i].e_vc));
            chk($sformatf("v%0d_err", i), 32'(route_err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d_active", i), 32'(vc_active), 32'(tbl[i].e_st == 2'd3));
        end
        chk("wrap_rr", 32'(dut.rr_ptr), 1);

        // No availability on port 4: forced grant is ignored, then VC3 wins and rr wraps.
        do_reset();
        drive(1,0,0,0,0,0);
        drive(0,1,4,0,0,0);
        drive(0,0,0,0,1,0);
        chk("noavail_req", 32'(req_vc), 0);
        chk("noavail_state", 32'(state), 2);
        drive(0,0,0,0,1,0);
        chk("noavail_hold", 32'(state), 2);
        drive(0,0,0,20'h80000,0,0);
        chk("vc3_req", 32'(req_vc), 32'h80000);
        drive(0,0,0,20'h80000,1,0);
        drive(0,0,0,0,0,0);
        chk("vc3_state", 32'(state), 3);
        chk("vc3_port", 32'(alloc_port), 4);
        chk("vc3_vc", 32'(alloc_vc), 3);
        chk("vc3_rr", 32'(dut.rr_ptr), 0);

        // Availability change mid-VA on port 3: request moves from VC1 to VC2 without a clock.
        drive(0,0,0,0,0,1);
        drive(1,0,0,0,0,0);
        drive(0,1,3,0,0,0);
        drive(0,0,0,20'h06000,0,0);
        chk("move_req_vc1", 32'(req_vc), 32'h02000);
        out_vc_avail = 20'h04000;
        #1;
        chk("move_req_vc2", 32'(req_vc), 32'h04000);
        drive(0,0,0,20'h04000,1,0);
        drive(0,0,0,0,0,0);
        chk("move_state", 32'(state), 3);
        chk("move_vc", 32'(alloc_vc), 2);
        chk("move_rr", 32'(dut.rr_ptr), 3);

        // Reset while ACTIVE.
        do_reset();
        chk("rstact_state", 32'(state), 0);
        chk("rstact_port", 32'(alloc_port), 0);
        chk("rstact_vc", 32'(alloc_vc), 0);

        // Reset while VA with a live request.
        drive(1,0,0,0,0,0);
        drive(0,1,2,0,0,0);
        drive(0,0,0,F,0,0);
        chk("rstva_pre_req", 32'(req_vc), 32'h00100);
        do_reset();
        chk("rstva_state", 32'(state), 0);
        chk("rstva_req", 32'(req_vc), 0);
        chk("rstva_port", 32'(alloc_port), 0);

        // Bad route: sticky error, no request, stuck in VA until reset.
        drive(1,0,0,0,0,0);
        drive(0,1,5,0,0,0);
        drive(0,0,0,F,1,0);
        chk("bad_state", 32'(state), 2);
        chk("bad_req", 32'(req_vc), 0);
        chk("bad_err", 32'(route_err), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0,0,0,F,1,1);
            chk($sformatf("bad_stuck%0d", k), 32'(state), 2);
            chk($sformatf("bad_req%0d", k), 32'(req_vc), 0);
        end
        do_reset();
        chk("bad_rst_err", 32'(route_err), 0);
        chk("bad_rst_state", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
